// File: rtl/msrv32_branch_resolve_bht_pkg.sv
// ----------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the execute-stage branch resolver:
//   - major opcode constants (instr[6:2]) for conditional branch, JAL, JALR
//   - func3 constants for the conditional branch flavours and JALR
//   - 2-bit saturating counter encodings used by the branch history table
//   - bht_next(): one training step of a saturating counter
// ----------------------------------------------------------------------------
package msrv32_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    // Move one step towards the observed direction, sticking at either end.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
        bht_cnt_t nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/msrv32_branch_resolve_bht_if.sv
// ----------------------------------------------------------------------------
// msrv32_branch_resolve_bht_if
// Bundles the fetch-side lookup port and the execute-side resolve port of the
// branch resolver.
//   master : the pipeline (drives lookups and resolving instructions)
//   slave  : the resolver (returns prediction, decision and perf counters)
// Lookup  : pc_fetch_in, lookup_en_in -> predict_taken_out
// Resolve : resolve_valid_in, stall_in, pc_ex_in, opcode_in, func3_in,
//           rs1_in, rs2_in, predicted_taken_in
//        -> resolved_valid_out, branch_taken_out, mispredict_out, illegal_out,
//           branch_count_out, mispredict_count_out
// ----------------------------------------------------------------------------
interface msrv32_branch_resolve_bht_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  pc_fetch_in;
    logic             lookup_en_in;
    logic             predict_taken_out;

    logic             resolve_valid_in;
    logic             stall_in;
    logic [XLEN-1:0]  pc_ex_in;
    logic [4:0]       opcode_in;
    logic [2:0]       func3_in;
    logic [XLEN-1:0]  rs1_in;
    logic [XLEN-1:0]  rs2_in;
    logic             predicted_taken_in;

    logic             resolved_valid_out;
    logic             branch_taken_out;
    logic             mispredict_out;
    logic             illegal_out;
    logic [CNT_W-1:0] branch_count_out;
    logic [CNT_W-1:0] mispredict_count_out;

    modport master (
        output pc_fetch_in, lookup_en_in,
        output resolve_valid_in, stall_in, pc_ex_in, opcode_in, func3_in,
        output rs1_in, rs2_in, predicted_taken_in,
        input  predict_taken_out,
        input  resolved_valid_out, branch_taken_out, mispredict_out, illegal_out,
        input  branch_count_out, mispredict_count_out
    );

    modport slave (
        input  pc_fetch_in, lookup_en_in,
        input  resolve_valid_in, stall_in, pc_ex_in, opcode_in, func3_in,
        input  rs1_in, rs2_in, predicted_taken_in,
        output predict_taken_out,
        output resolved_valid_out, branch_taken_out, mispredict_out, illegal_out,
        output branch_count_out, mispredict_count_out
    );
endinterface

// File: rtl/msrv32_branch_resolve_bht_cmp.sv
// ----------------------------------------------------------------------------
// msrv32_branch_cmp
// Purely combinational branch/jump decision over XLEN-bit operands.
//   rs1, rs2 : operands
//   opcode   : instr[6:2]
//   func3    : instr[14:12]
//   taken    : instruction redirects the PC
//   illegal  : func3 not supported for a branch or JALR opcode
// ----------------------------------------------------------------------------
module msrv32_branch_cmp
    import msrv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      opcode,
    input  logic [2:0]      func3,
    output logic            taken,
    output logic            illegal
);

    // Decode the opcode/func3 pair; BLT/BGE use two's-complement ordering,
    // BLTU/BGEU plain magnitude. Unknown opcodes are simply not taken.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_BRANCH: begin
                case (func3)
                    F3_BEQ:  taken = (rs1 == rs2);
                    F3_BNE:  taken = (rs1 != rs2);
                    F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
                    F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
                    F3_BLTU: taken = (rs1 <  rs2);
                    F3_BGEU: taken = (rs1 >= rs2);
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                taken = 1'b1;
            end
            OP_JALR: begin
                if (func3 == F3_JALR) begin
                    taken = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_branch_resolve_bht.sv
// ----------------------------------------------------------------------------
// msrv32_branch_resolve_bht
// Execute-stage branch resolver with a direct-mapped table of 2-bit
// saturating counters, read by fetch through a registered lookup port.
//   ms_riscv32_mp_clk_in   : clock, rising edge
//   ms_riscv32_mp_rst_n_in : asynchronous active-low reset
//   bus (slave)            : lookup port, resolve port, registered decision,
//                            mispredict/illegal flags and perf counters
// Table index is pc[IDXW+1:2]. Only legal conditional branches train the
// table and step the counters; JAL/JALR resolve but never train.
// ----------------------------------------------------------------------------
module msrv32_branch_resolve_bht
    import msrv32_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic                        ms_riscv32_mp_clk_in,
    input  logic                        ms_riscv32_mp_rst_n_in,
    msrv32_branch_resolve_bht_if.slave  bus
);

    localparam int IDXW = $clog2(BHT_ENTRIES);

    bht_cnt_t         bht [BHT_ENTRIES];
    logic [IDXW-1:0]  lookup_idx;
    logic [IDXW-1:0]  train_idx;

    logic             cmp_taken;
    logic             cmp_illegal;
    logic             is_ctrl;
    logic             is_cond;
    logic             accept;
    logic             train;
    logic             mispredict_next;

    logic             predict_q;
    logic             resolved_valid_q;
    logic             taken_q;
    logic             mispredict_q;
    logic             illegal_q;
    logic [CNT_W-1:0] branch_count_q;
    logic [CNT_W-1:0] mispredict_count_q;

    logic             unused_pc_bits;

    msrv32_branch_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .rs1    (bus.rs1_in),
        .rs2    (bus.rs2_in),
        .opcode (bus.opcode_in),
        .func3  (bus.func3_in),
        .taken  (cmp_taken),
        .illegal(cmp_illegal)
    );

    assign lookup_idx = bus.pc_fetch_in[IDXW+1:2];
    assign train_idx  = bus.pc_ex_in[IDXW+1:2];

    // The byte offset and the PC bits above the index never reach the table.
    assign unused_pc_bits = ^{bus.pc_fetch_in[XLEN-1:IDXW+2], bus.pc_fetch_in[1:0],
                              bus.pc_ex_in[XLEN-1:IDXW+2], bus.pc_ex_in[1:0]};

    // Mispredict only means something for a legal control-transfer; illegal
    // encodings and ordinary instructions always report 0.
    assign is_ctrl = ((bus.opcode_in == OP_BRANCH) || (bus.opcode_in == OP_JAL) ||
                      (bus.opcode_in == OP_JALR)) && !cmp_illegal;
    assign is_cond = (bus.opcode_in == OP_BRANCH) && !cmp_illegal;

    assign accept          = bus.resolve_valid_in && !bus.stall_in;
    assign train           = accept && is_cond;
    assign mispredict_next = is_ctrl && (cmp_taken ^ bus.predicted_taken_in);

    // Fetch-side read of the counter MSB. A lookup in the same cycle as a
    // training write to the same entry sees the old value; there is no bypass.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            predict_q <= 1'b0;
        end else if (bus.lookup_en_in) begin
            predict_q <= bht[lookup_idx][1];
        end
    end

    // Table training: every entry starts weakly not-taken and steps toward
    // the resolved direction of each legal conditional branch.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= WNT;
            end
        end else if (train) begin
            bht[train_idx] <= bht_next(bht[train_idx], cmp_taken);
        end
    end

    // Resolve outputs: valid pulses for each accepted instruction, the other
    // flags load only on accept and otherwise keep the last result.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            resolved_valid_q <= 1'b0;
            taken_q          <= 1'b0;
            mispredict_q     <= 1'b0;
            illegal_q        <= 1'b0;
        end else begin
            resolved_valid_q <= accept;
            if (accept) begin
                taken_q      <= cmp_taken;
                mispredict_q <= mispredict_next;
                illegal_q    <= cmp_illegal;
            end
        end
    end

    // Performance counters follow training exactly and wrap naturally.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (train) begin
            branch_count_q <= branch_count_q + 1'b1;
            if (mispredict_next) begin
                mispredict_count_q <= mispredict_count_q + 1'b1;
            end
        end
    end

    assign bus.predict_taken_out    = predict_q;
    assign bus.resolved_valid_out   = resolved_valid_q;
    assign bus.branch_taken_out     = taken_q;
    assign bus.mispredict_out       = mispredict_q;
    assign bus.illegal_out          = illegal_q;
    assign bus.branch_count_out     = branch_count_q;
    assign bus.mispredict_count_out = mispredict_count_q;

endmodule

// File: tb/tb_msrv32_branch_resolve_bht.sv
// ----------------------------------------------------------------------------
// tb_msrv32_branch_resolve_bht
// Directed bench for the branch resolver. Each resolving instruction pushes
// its hand-computed result onto a scoreboard queue; a monitor pops and
// compares whenever resolved_valid_out is seen. Lookups and stall/reset
// behaviour are compared directly from the main sequence.
// ----------------------------------------------------------------------------
module tb_msrv32_branch_resolve_bht;
    import msrv32_pkg::*;

    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic        mis;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    msrv32_branch_resolve_bht_if #(.XLEN(32), .CNT_W(32)) bus_if();

    msrv32_branch_resolve_bht #(
        .XLEN(32),
        .BHT_ENTRIES(64),
        .CNT_W(32)
    ) dut (
        .ms_riscv32_mp_clk_in  (clk),
        .ms_riscv32_mp_rst_n_in(rst_n),
        .bus                   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one resolving instruction for a single cycle and queue its result.
    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] op,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic pred,
                                 input logic e_taken, input logic e_ill,
                                 input logic e_mis, input logic [31:0] e_bc,
                                 input logic [31:0] e_mc);
        exp_t e;
        @(negedge clk);
        bus_if.pc_ex_in           = pc;
        bus_if.opcode_in          = op;
        bus_if.func3_in           = f3;
        bus_if.rs1_in             = a;
        bus_if.rs2_in             = b;
        bus_if.predicted_taken_in = pred;
        bus_if.resolve_valid_in   = 1'b1;
        e.taken   = e_taken;
        e.illegal = e_ill;
        e.mis     = e_mis;
        e.bc      = e_bc;
        e.mc      = e_mc;
        sb.push_back(e);
        @(negedge clk);
        bus_if.resolve_valid_in = 1'b0;
    endtask

    task automatic doLookup(input logic [31:0] pc, input logic expected);
        @(negedge clk);
        bus_if.pc_fetch_in  = pc;
        bus_if.lookup_en_in = 1'b1;
        @(negedge clk);
        bus_if.lookup_en_in = 1'b0;
        checkOutput($sformatf("lookup_%0h", pc), {31'b0, bus_if.predict_taken_out},
                    {31'b0, expected});
    endtask

    // Scoreboard monitor: every presented result must match the oldest
    // queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus_if.resolved_valid_out) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("taken",   {31'b0, bus_if.branch_taken_out}, {31'b0, e.taken});
                checkOutput("illegal", {31'b0, bus_if.illegal_out},      {31'b0, e.illegal});
                checkOutput("mispred", {31'b0, bus_if.mispredict_out},   {31'b0, e.mis});
                checkOutput("br_cnt",  bus_if.branch_count_out,          e.bc);
                checkOutput("mis_cnt", bus_if.mispredict_count_out,      e.mc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n                     = 1'b0;
        bus_if.pc_fetch_in        = '0;
        bus_if.lookup_en_in       = 1'b0;
        bus_if.resolve_valid_in   = 1'b0;
        bus_if.stall_in           = 1'b0;
        bus_if.pc_ex_in           = '0;
        bus_if.opcode_in          = '0;
        bus_if.func3_in           = '0;
        bus_if.rs1_in             = '0;
        bus_if.rs2_in             = '0;
        bus_if.predicted_taken_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid",   {31'b0, bus_if.resolved_valid_out}, 32'd0);
        checkOutput("rst_predict", {31'b0, bus_if.predict_taken_out},  32'd0);
        checkOutput("rst_bc",      bus_if.branch_count_out,            32'd0);
        rst_n = 1'b1;

        // Every entry starts weakly not-taken.
        for (int i = 0; i < 64; i++) begin
            doLookup(32'(i) << 2, 1'b0);
        end

        // Signed versus unsigned compares.
        applyStimulus(32'h204, OP_BRANCH, F3_BLT,  32'hFFFF_FFFF, 32'h1, 1'b0, 1, 0, 1, 1, 1);
        applyStimulus(32'h208, OP_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, 0, 0, 2, 1);
        applyStimulus(32'h20C, OP_BRANCH, F3_BGE,  32'h8000_0000, 32'h8000_0000, 1'b1, 1, 0, 0, 3, 1);
        doLookup(32'h204, 1'b1);
        doLookup(32'h208, 1'b0);
        doLookup(32'h20C, 1'b1);

        // Counter saturation at both ends on entry 0.
        applyStimulus(32'h100, OP_BRANCH, F3_BEQ, 32'd5, 32'd5, 1'b0, 1, 0, 1, 4, 2);
        applyStimulus(32'h100, OP_BRANCH, F3_BEQ, 32'd5, 32'd5, 1'b1, 1, 0, 0, 5, 2);
        doLookup(32'h100, 1'b1);
        applyStimulus(32'h100, OP_BRANCH, F3_BEQ, 32'd5, 32'd6, 1'b1, 0, 0, 1, 6, 3);
        applyStimulus(32'h100, OP_BRANCH, F3_BEQ, 32'd5, 32'd6, 1'b1, 0, 0, 1, 7, 4);
        applyStimulus(32'h100, OP_BRANCH, F3_BEQ, 32'd5, 32'd6, 1'b1, 0, 0, 1, 8, 5);
        applyStimulus(32'h100, OP_BRANCH, F3_BEQ, 32'd5, 32'd6, 1'b1, 0, 0, 1, 9, 6);
        doLookup(32'h100, 1'b0);
        applyStimulus(32'h100, OP_BRANCH, F3_BEQ, 32'd5, 32'd6, 1'b0, 0, 0, 0, 10, 6);
        doLookup(32'h100, 1'b0);
        applyStimulus(32'h100, OP_BRANCH, F3_BEQ, 32'd5, 32'd5, 1'b0, 1, 0, 1, 11, 7);
        doLookup(32'h100, 1'b0);

        // Mispredicts: BNE counts, JAL does not train.
        applyStimulus(32'h310, OP_BRANCH, F3_BNE, 32'd1, 32'd2, 1'b0, 1, 0, 1, 12, 8);
        applyStimulus(32'h314, OP_JAL,    3'b000, 32'd0, 32'd0, 1'b0, 1, 0, 1, 12, 8);
        doLookup(32'h314, 1'b0);

        // Stall holds everything for three cycles, then exactly one update.
        @(negedge clk);
        bus_if.pc_ex_in           = 32'h318;
        bus_if.opcode_in          = OP_BRANCH;
        bus_if.func3_in           = F3_BEQ;
        bus_if.rs1_in             = 32'd7;
        bus_if.rs2_in             = 32'd7;
        bus_if.predicted_taken_in = 1'b0;
        bus_if.resolve_valid_in   = 1'b1;
        bus_if.stall_in           = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'b0, bus_if.resolved_valid_out}, 32'd0);
            checkOutput("stall_bc",    bus_if.branch_count_out,            32'd12);
        end
        bus_if.stall_in = 1'b0;
        sb.push_back('{taken: 1'b1, illegal: 1'b0, mis: 1'b1, bc: 32'd13, mc: 32'd9});
        @(negedge clk);
        bus_if.resolve_valid_in = 1'b0;
        @(negedge clk);
        checkOutput("post_stall_valid", {31'b0, bus_if.resolved_valid_out}, 32'd0);
        checkOutput("post_stall_bc",    bus_if.branch_count_out,            32'd13);
        doLookup(32'h318, 1'b1);

        // Illegal encodings neither train nor count.
        applyStimulus(32'h31C, OP_BRANCH, 3'b010, 32'd1, 32'd1, 1'b1, 0, 1, 0, 13, 9);
        doLookup(32'h31C, 1'b0);
        applyStimulus(32'h31C, OP_BRANCH, F3_BEQ, 32'd3, 32'd3, 1'b0, 1, 0, 1, 14, 10);
        doLookup(32'h31C, 1'b1);
        applyStimulus(32'h324, OP_JALR,   3'b001, 32'd0, 32'd0, 1'b0, 0, 1, 0, 14, 10);
        applyStimulus(32'h324, OP_JALR,   F3_JALR, 32'd0, 32'd0, 1'b1, 1, 0, 0, 14, 10);
        applyStimulus(32'h328, 5'b01100,  3'b000, 32'd4, 32'd4, 1'b1, 0, 0, 0, 14, 10);

        // Asynchronous reset with results on the outputs and a resolve in flight.
        applyStimulus(32'h320, OP_BRANCH, F3_BEQ, 32'd9, 32'd9, 1'b0, 1, 0, 1, 15, 11);
        bus_if.pc_ex_in         = 32'h320;
        bus_if.resolve_valid_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid",   {31'b0, bus_if.resolved_valid_out}, 32'd0);
        checkOutput("arst_taken",   {31'b0, bus_if.branch_taken_out},   32'd0);
        checkOutput("arst_mispred", {31'b0, bus_if.mispredict_out},     32'd0);
        checkOutput("arst_illegal", {31'b0, bus_if.illegal_out},        32'd0);
        checkOutput("arst_predict", {31'b0, bus_if.predict_taken_out},  32'd0);
        checkOutput("arst_bc",      bus_if.branch_count_out,            32'd0);
        checkOutput("arst_mc",      bus_if.mispredict_count_out,        32'd0);
        @(negedge clk);
        bus_if.resolve_valid_in = 1'b0;
        rst_n = 1'b1;
        doLookup(32'h31C, 1'b0);
        doLookup(32'h204, 1'b0);
        checkOutput("post_rst_bc", bus_if.branch_count_out, 32'd0);
        checkOutput("sb_empty",    32'(sb.size()),          32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
